// File: rtl/pipe_pkg.sv
// Shared opcode bit indices and the pipeline stage payload for the MAC pipeline.
package pipe_pkg;

  localparam int unsigned OP_W        = 6;
  localparam int unsigned OP_NOP      = 0;
  localparam int unsigned OP_LD_DATA  = 1;
  localparam int unsigned OP_LD_COEFF = 2;
  localparam int unsigned OP_ADD      = 3;
  localparam int unsigned OP_MULT     = 4;
  localparam int unsigned OP_WRITE    = 5;

  typedef struct packed {
    logic mult;
    logic add;
    logic wr;
  } stage_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: operand registers, operand snapshot, signed multiplier,
// saturating accumulator, result register and sticky saturation flag.
module mac_lane #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ld_d_we,
  input  logic                     ld_c_we,
  input  logic signed [DATA_W-1:0] ld_d,
  input  logic signed [DATA_W-1:0] ld_c,
  input  logic                     snap,
  input  logic                     mul,
  input  logic                     add,
  input  logic                     wr,
  output logic signed [ACC_W-1:0]  res,
  output logic                     sat
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] opd, opc, snd, snc;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc, acc_nxt_c;
  logic [ACC_W:0]           sum_c;
  logic                     ovf_c;

  // Accumulate with one guard bit; clamp when the guard and sign bits disagree.
  always_comb begin
    sum_c     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
    ovf_c     = add && (sum_c[ACC_W] != sum_c[ACC_W-1]);
    acc_nxt_c = acc;
    if (add) begin
      if (ovf_c) acc_nxt_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
      else       acc_nxt_c = sum_c[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opd  <= '0;
      opc  <= '0;
      snd  <= '0;
      snc  <= '0;
      prod <= '0;
      acc  <= '0;
      res  <= '0;
      sat  <= 1'b0;
    end else begin
      if (ld_d_we) opd <= ld_d;
      if (ld_c_we) opc <= ld_c;
      if (snap) begin
        snd <= opd;
        snc <= opc;
      end
      if (mul) prod <= PW'(snd) * PW'(snc);
      // WRITE publishes the updated sum, then restarts the lane from zero.
      if (wr) begin
        res <= acc_nxt_c;
        acc <= '0;
        sat <= 1'b0;
      end else begin
        acc <= acc_nxt_c;
        if (ovf_c) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_pipeline.sv
// Instruction-driven multi-lane MAC pipeline with delayed operand loads and
// load-to-MULT collision handling (stall or squash).
module mac_pipeline
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LD_LAT     = 2,
  parameter int unsigned STALL_MODE = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  input  logic [OP_W-1:0]           inst,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES*DATA_W-1:0]   coeff_in,
  output logic                      out_valid,
  output logic [LANES*ACC_W-1:0]    out_data,
  output logic                      collide,
  output logic [LANES-1:0]          sat,
  output logic                      busy
);

  localparam int unsigned VW = LANES * DATA_W;

  logic [OP_W-1:0]   op_c;
  logic              bubble_c, coll_c, squash_c, accept_c, ld_any_c;
  stage_t            issue_c, s1, s2;
  logic              s3_add, s3_wr;
  logic [LD_LAT-1:0] ld_hist, ldd_v, ldc_v;
  logic [VW-1:0]     ldd_q [LD_LAT];
  logic [VW-1:0]     ldc_q [LD_LAT];

  // Decode, collision detection and the combinational accept handshake.
  always_comb begin
    op_c     = inst & ~(OP_W'(1) << OP_NOP);
    bubble_c = (op_c == '0);
    coll_c   = 1'b0;
    for (int i = 0; i < int'(LD_LAT) - 1; i++) coll_c = coll_c | ld_hist[i];
    inst_ready   = !((STALL_MODE != 0) && inst_valid && op_c[OP_MULT] && coll_c);
    accept_c     = inst_valid && inst_ready;
    squash_c     = (STALL_MODE == 0) && coll_c && op_c[OP_MULT];
    ld_any_c     = op_c[OP_LD_DATA] || op_c[OP_LD_COEFF];
    issue_c.mult = op_c[OP_MULT] && !squash_c;
    issue_c.add  = op_c[OP_ADD] && !squash_c;
    issue_c.wr   = op_c[OP_WRITE];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1        <= '0;
      s2        <= '0;
      s3_add    <= 1'b0;
      s3_wr     <= 1'b0;
      out_valid <= 1'b0;
      collide   <= 1'b0;
      ld_hist   <= '0;
      ldd_v     <= '0;
      ldc_v     <= '0;
      for (int i = 0; i < int'(LD_LAT); i++) begin
        ldd_q[i] <= '0;
        ldc_q[i] <= '0;
      end
    end else begin
      s1        <= (accept_c && !bubble_c) ? issue_c : '0;
      s2        <= s1;
      s3_add    <= s2.add;
      s3_wr     <= s2.wr;
      out_valid <= s3_wr;
      collide   <= accept_c && squash_c;
      // Load delay line; its last stage writes the lane operand registers.
      ld_hist[0] <= accept_c && ld_any_c;
      ldd_v[0]   <= accept_c && op_c[OP_LD_DATA];
      ldc_v[0]   <= accept_c && op_c[OP_LD_COEFF];
      ldd_q[0]   <= data_in;
      ldc_q[0]   <= coeff_in;
      for (int i = 1; i < int'(LD_LAT); i++) begin
        ld_hist[i] <= ld_hist[i-1];
        ldd_v[i]   <= ldd_v[i-1];
        ldc_v[i]   <= ldc_v[i-1];
        ldd_q[i]   <= ldd_q[i-1];
        ldc_q[i]   <= ldc_q[i-1];
      end
    end
  end

  assign busy = s1.mult || s1.add || s1.wr || s2.mult || s2.add || s2.wr ||
                s3_add || s3_wr || (|ld_hist);

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    mac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .ld_d_we (ldd_v[LD_LAT-1]),
      .ld_c_we (ldc_v[LD_LAT-1]),
      .ld_d    (ldd_q[LD_LAT-1][g*DATA_W +: DATA_W]),
      .ld_c    (ldc_q[LD_LAT-1][g*DATA_W +: DATA_W]),
      .snap    (s1.mult),
      .mul     (s2.mult),
      .add     (s3_add),
      .wr      (s3_wr),
      .res     (out_data[g*ACC_W +: ACC_W]),
      .sat     (sat[g])
    );
  end

endmodule
